// File: rtl/machine_counters_if.sv
// CSR access, retire/inhibit inputs and counter outputs of the machine counter block.
// The slave modport is used by the counters and the master modport by whoever drives the CSR bus.
interface machine_counters_if;
   logic [11:0] csr_addr_in;
   logic        wr_en_in;
   logic [31:0] data_wr_in;
   logic        instret_inc_in;
   logic        mcountinhibit_cy_in;
   logic        mcountinhibit_ir_in;
   logic [31:0] csr_data_out;
   logic        csr_hit_out;
   logic        illegal_wr_out;
   logic [63:0] mcycle_out;
   logic [63:0] minstret_out;

   modport slave (
      input  csr_addr_in,
      input  wr_en_in,
      input  data_wr_in,
      input  instret_inc_in,
      input  mcountinhibit_cy_in,
      input  mcountinhibit_ir_in,
      output csr_data_out,
      output csr_hit_out,
      output illegal_wr_out,
      output mcycle_out,
      output minstret_out
   );

   modport master (
      output csr_addr_in,
      output wr_en_in,
      output data_wr_in,
      output instret_inc_in,
      output mcountinhibit_cy_in,
      output mcountinhibit_ir_in,
      input  csr_data_out,
      input  csr_hit_out,
      input  illegal_wr_out,
      input  mcycle_out,
      input  minstret_out
   );
endinterface

// File: rtl/machine_counters.sv
// 64-bit mcycle/minstret machine counters with CSR read/write of both halves
// and read-only user shadows (cycle/cycleh, instret/instreth).
module machine_counters #(
   parameter logic [11:0] MCYCLE_ADDR    = 12'hB00,
   parameter logic [11:0] MINSTRET_ADDR  = 12'hB02,
   parameter logic [11:0] MCYCLEH_ADDR   = 12'hB80,
   parameter logic [11:0] MINSTRETH_ADDR = 12'hB82,
   parameter logic [11:0] CYCLE_ADDR     = 12'hC00,
   parameter logic [11:0] INSTRET_ADDR   = 12'hC02,
   parameter logic [11:0] CYCLEH_ADDR    = 12'hC80,
   parameter logic [11:0] INSTRETH_ADDR  = 12'hC82,
   parameter logic [63:0] COUNTER_RESET  = 64'h0
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   machine_counters_if.slave  bus_io
);

   logic [63:0] mcycle_q, mcycle_d;
   logic [63:0] minstret_q, minstret_d;
   logic        illegal_wr_q, illegal_wr_d;

   logic        wr_mcycle_lo, wr_mcycle_hi;
   logic        wr_minstret_lo, wr_minstret_hi;
   logic        wr_shadow;
   logic [31:0] rd_data;
   logic        rd_hit;

   // Write decode
   always_comb begin
      wr_mcycle_lo   = bus_io.wr_en_in && (bus_io.csr_addr_in == MCYCLE_ADDR);
      wr_mcycle_hi   = bus_io.wr_en_in && (bus_io.csr_addr_in == MCYCLEH_ADDR);
      wr_minstret_lo = bus_io.wr_en_in && (bus_io.csr_addr_in == MINSTRET_ADDR);
      wr_minstret_hi = bus_io.wr_en_in && (bus_io.csr_addr_in == MINSTRETH_ADDR);
      wr_shadow      = bus_io.wr_en_in &&
                       ((bus_io.csr_addr_in == CYCLE_ADDR)  ||
                        (bus_io.csr_addr_in == INSTRET_ADDR) ||
                        (bus_io.csr_addr_in == CYCLEH_ADDR)  ||
                        (bus_io.csr_addr_in == INSTRETH_ADDR));
   end

   // Next-state: low-half write, then high-half write, then increment, else hold
   always_comb begin
      mcycle_d = mcycle_q;
      if (wr_mcycle_lo) begin
         mcycle_d[31:0] = bus_io.data_wr_in;
      end else if (wr_mcycle_hi) begin
         mcycle_d[63:32] = bus_io.data_wr_in;
      end else if (!bus_io.mcountinhibit_cy_in) begin
         mcycle_d = mcycle_q + 64'd1;
      end
   end

   always_comb begin
      minstret_d = minstret_q;
      if (wr_minstret_lo) begin
         minstret_d[31:0] = bus_io.data_wr_in;
      end else if (wr_minstret_hi) begin
         minstret_d[63:32] = bus_io.data_wr_in;
      end else if (!bus_io.mcountinhibit_ir_in && bus_io.instret_inc_in) begin
         minstret_d = minstret_q + 64'd1;
      end
   end

   assign illegal_wr_d = wr_shadow;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         mcycle_q     <= COUNTER_RESET;
         minstret_q   <= COUNTER_RESET;
         illegal_wr_q <= 1'b0;
      end else begin
         mcycle_q     <= mcycle_d;
         minstret_q   <= minstret_d;
         illegal_wr_q <= illegal_wr_d;
      end
   end

   // Reads see the pre-edge register value; shadows alias their M-mode counterparts
   always_comb begin
      rd_data = 32'h0;
      rd_hit  = 1'b1;
      case (bus_io.csr_addr_in)
         MCYCLE_ADDR,    CYCLE_ADDR:    rd_data = mcycle_q[31:0];
         MCYCLEH_ADDR,   CYCLEH_ADDR:   rd_data = mcycle_q[63:32];
         MINSTRET_ADDR,  INSTRET_ADDR:  rd_data = minstret_q[31:0];
         MINSTRETH_ADDR, INSTRETH_ADDR: rd_data = minstret_q[63:32];
         default:                       rd_hit  = 1'b0;
      endcase
   end

   assign bus_io.csr_data_out   = rd_data;
   assign bus_io.csr_hit_out    = rd_hit;
   assign bus_io.illegal_wr_out = illegal_wr_q;
   assign bus_io.mcycle_out     = mcycle_q;
   assign bus_io.minstret_out   = minstret_q;

endmodule

// File: tb/tb_machine_counters.sv
// Self-checking bench for machine_counters: vector table plus a scoreboard of
// expected post-edge counter state, with hand-written corner-case sequences.
module tb_machine_counters;

   typedef struct {
      string       name;
      logic [11:0] addr;
      logic        wr;
      logic [31:0] data;
      logic        inc;
      logic        cy;
      logic        ir;
   } stim_t;

   typedef struct {
      string       name;
      logic [63:0] cyc;
      logic [63:0] ins;
      logic        ill;
   } exp_t;

   logic clk;
   logic rst_n;
   machine_counters_if bus ();

   machine_counters dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus_io   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   exp_t        sb[$];
   stim_t       vec[$];
   logic [63:0] m_cyc;
   logic [63:0] m_ins;
   logic [63:0] saved;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic stim_t mk(input string name, input logic [11:0] addr, input logic wr,
                                input logic [31:0] data, input logic inc, input logic cy,
                                input logic ir);
      stim_t s;
      s.name = name; s.addr = addr; s.wr = wr; s.data = data;
      s.inc = inc; s.cy = cy; s.ir = ir;
      return s;
   endfunction

   // Called #1 after a rising edge; checks the combinational read, then the post-edge state.
   task automatic drive_cycle(input stim_t s);
      exp_t        e;
      exp_t        got;
      logic [31:0] exp_rd;
      logic        exp_hit;
      bus.csr_addr_in         = s.addr;
      bus.wr_en_in            = s.wr;
      bus.data_wr_in          = s.data;
      bus.instret_inc_in      = s.inc;
      bus.mcountinhibit_cy_in = s.cy;
      bus.mcountinhibit_ir_in = s.ir;
      #1;
      exp_hit = 1'b1;
      case (s.addr)
         12'hB00, 12'hC00: exp_rd = m_cyc[31:0];
         12'hB80, 12'hC80: exp_rd = m_cyc[63:32];
         12'hB02, 12'hC02: exp_rd = m_ins[31:0];
         12'hB82, 12'hC82: exp_rd = m_ins[63:32];
         default: begin exp_rd = 32'h0; exp_hit = 1'b0; end
      endcase
      check({s.name, "/rd_data"}, {32'h0, bus.csr_data_out}, {32'h0, exp_rd});
      check({s.name, "/hit"}, {63'h0, bus.csr_hit_out}, {63'h0, exp_hit});

      e.name = s.name;
      if (s.wr && s.addr == 12'hB00)      e.cyc = {m_cyc[63:32], s.data};
      else if (s.wr && s.addr == 12'hB80) e.cyc = {s.data, m_cyc[31:0]};
      else if (!s.cy)                     e.cyc = m_cyc + 64'd1;
      else                                e.cyc = m_cyc;
      if (s.wr && s.addr == 12'hB02)      e.ins = {m_ins[63:32], s.data};
      else if (s.wr && s.addr == 12'hB82) e.ins = {s.data, m_ins[31:0]};
      else if (!s.ir && s.inc)            e.ins = m_ins + 64'd1;
      else                                e.ins = m_ins;
      e.ill = s.wr && (s.addr == 12'hC00 || s.addr == 12'hC02 ||
                       s.addr == 12'hC80 || s.addr == 12'hC82);
      sb.push_back(e);

      @(posedge clk);
      #1;
      got = sb.pop_front();
      check({got.name, "/mcycle"}, bus.mcycle_out, got.cyc);
      check({got.name, "/minstret"}, bus.minstret_out, got.ins);
      check({got.name, "/illegal"}, {63'h0, bus.illegal_wr_out}, {63'h0, got.ill});
      m_cyc = got.cyc;
      m_ins = got.ins;
   endtask

   task automatic idle(input int n, input logic inc, input logic cy, input logic ir);
      for (int i = 0; i < n; i++) drive_cycle(mk("idle", 12'h000, 1'b0, 32'h0, inc, cy, ir));
   endtask

   initial begin
      rst_n = 1'b0;
      bus.csr_addr_in = 12'h0; bus.wr_en_in = 1'b0; bus.data_wr_in = 32'h0;
      bus.instret_inc_in = 1'b0; bus.mcountinhibit_cy_in = 1'b0; bus.mcountinhibit_ir_in = 1'b0;
      m_cyc = 64'h0;
      m_ins = 64'h0;
      repeat (2) @(posedge clk);
      #1;
      check("reset/mcycle", bus.mcycle_out, 64'h0);
      check("reset/minstret", bus.minstret_out, 64'h0);
      check("reset/illegal", {63'h0, bus.illegal_wr_out}, 64'h0);
      rst_n = 1'b1;

      // Free-running count from reset
      idle(10, 1'b0, 1'b0, 1'b0);
      check("t1/mcycle10", bus.mcycle_out, 64'd10);
      check("t1/minstret0", bus.minstret_out, 64'd0);

      // Vector table: carry, wrap, writes, misses, shadows
      vec.push_back(mk("wr_mcycleh0",   12'hB80, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0));
      vec.push_back(mk("wr_mcycle_ff",  12'hB00, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0));
      vec.push_back(mk("carry",         12'hB80, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0));
      vec.push_back(mk("wr_mcycleh_ff", 12'hB80, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0));
      vec.push_back(mk("wr_mcycle_ff2", 12'hB00, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0));
      vec.push_back(mk("wrap",          12'hC80, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0));
      vec.push_back(mk("wr_minstret",   12'hB02, 1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0));
      vec.push_back(mk("wr_minstreth",  12'hB82, 1'b1, 32'h0000_0007, 1'b1, 1'b1, 1'b1));
      vec.push_back(mk("rd_instret",    12'hC02, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0));
      vec.push_back(mk("rd_instreth",   12'hC82, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0));
      vec.push_back(mk("wr_miss",       12'hB01, 1'b1, 32'h5555_5555, 1'b1, 1'b0, 1'b0));
      vec.push_back(mk("wr_miss2",      12'h300, 1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b0));
      vec.push_back(mk("wr_shadow_ih",  12'hC82, 1'b1, 32'h1111_1111, 1'b1, 1'b0, 1'b0));
      vec.push_back(mk("after_shadow",  12'hB82, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0));
      for (int i = 0; i < vec.size(); i++) drive_cycle(vec[i]);

      // Low-half write then increment, high half untouched
      saved = m_cyc;
      drive_cycle(mk("t3/wr_lo", 12'hB00, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0));
      check("t3/lo_written", {32'h0, bus.mcycle_out[31:0]}, 64'h1234_5678);
      idle(1, 1'b0, 1'b0, 1'b0);
      check("t3/lo_inc", {32'h0, bus.mcycle_out[31:0]}, 64'h1234_5679);
      check("t3/hi_held", {32'h0, bus.mcycle_out[63:32]}, {32'h0, saved[63:32]});

      // minstret inhibit then release
      saved = m_ins;
      idle(5, 1'b1, 1'b0, 1'b1);
      check("t4/held", bus.minstret_out, saved);
      idle(3, 1'b1, 1'b0, 1'b0);
      check("t4/plus3", bus.minstret_out, saved + 64'd3);

      // Write while inhibited still lands
      drive_cycle(mk("wr_cy_inh", 12'hB00, 1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b0));
      idle(2, 1'b0, 1'b1, 1'b0);

      // Illegal shadow write: one-cycle pulse, counting continues
      saved = m_cyc;
      drive_cycle(mk("t5/wr_cycle", 12'hC00, 1'b1, 32'h0000_DEAD, 1'b0, 1'b0, 1'b0));
      check("t5/pulse", {63'h0, bus.illegal_wr_out}, 64'h1);
      check("t5/counting", bus.mcycle_out, saved + 64'd1);
      drive_cycle(mk("t5/rd_cycle", 12'hC00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
      check("t5/pulse_gone", {63'h0, bus.illegal_wr_out}, 64'h0);
      drive_cycle(mk("t5/rd_mcycle", 12'hB00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));

      // Asynchronous reset between edges
      idle(3, 1'b1, 1'b0, 1'b0);
      bus.csr_addr_in = 12'hB00; bus.wr_en_in = 1'b1; bus.data_wr_in = 32'h7777_7777;
      #3;
      rst_n = 1'b0;
      #1;
      check("t6/mcycle_async", bus.mcycle_out, 64'h0);
      check("t6/minstret_async", bus.minstret_out, 64'h0);
      check("t6/illegal_async", {63'h0, bus.illegal_wr_out}, 64'h0);
      bus.wr_en_in = 1'b0;
      bus.instret_inc_in = 1'b0;
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      m_cyc = 64'd1;
      m_ins = 64'd0;
      check("t6/restart", bus.mcycle_out, m_cyc);
      idle(2, 1'b1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
